// File: rtl/ucode_sequencer.sv
// Microcode address generator for the multi-cycle RV32I core: decodes the fetched
// word into a class and walks that class's stage sequence, with stall, halt and retire count.
module ucode_sequencer #(
  parameter int          CNT_WIDTH  = 32,
  parameter logic [4:0]  HALT_CLASS = 5'd28
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [31:0]          imem_inst,
  input  logic                 stall,
  output logic [4:0]           inst_class,
  output logic [2:0]           stage,
  output logic                 halt,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } stage_e;

  typedef struct packed {
    logic       legal;
    logic [4:0] cls;
  } decode_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] CLS_LW    = 5'd20;
  localparam logic [4:0] CLS_SW    = 5'd21;
  localparam logic [4:0] CLS_BR    = 5'd24;
  localparam logic [4:0] CLS_BRU   = 5'd25;
  localparam logic [4:0] CLS_LUI   = 5'd26;
  localparam logic [4:0] CLS_AUIPC = 5'd27;

  function automatic decode_t ok(input logic [4:0] c);
    return '{legal: 1'b1, cls: c};
  endfunction

  function automatic decode_t decode(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [6:0] f7);
    decode_t d;
    d = '{legal: 1'b0, cls: HALT_CLASS};
    case (op)
      OP_R: begin
        case ({f7, f3})
          {F7_BASE, 3'd0}: d = ok(5'd0);
          {F7_ALT,  3'd0}: d = ok(5'd1);
          {F7_BASE, 3'd2}: d = ok(5'd2);
          {F7_BASE, 3'd3}: d = ok(5'd3);
          {F7_BASE, 3'd4}: d = ok(5'd4);
          {F7_BASE, 3'd6}: d = ok(5'd5);
          {F7_BASE, 3'd7}: d = ok(5'd6);
          {F7_BASE, 3'd1}: d = ok(5'd7);
          {F7_BASE, 3'd5}: d = ok(5'd8);
          {F7_ALT,  3'd5}: d = ok(5'd9);
          default: ;
        endcase
      end
      // Class 11 is a reserved hole; funct7 only matters for the shift forms.
      OP_IMM: begin
        case (f3)
          3'd0: d = ok(5'd10);
          3'd2: d = ok(5'd12);
          3'd3: d = ok(5'd13);
          3'd4: d = ok(5'd14);
          3'd6: d = ok(5'd15);
          3'd7: d = ok(5'd16);
          3'd1: if (f7 == F7_BASE) d = ok(5'd17);
          3'd5: begin
            if (f7 == F7_BASE)     d = ok(5'd18);
            else if (f7 == F7_ALT) d = ok(5'd19);
          end
          default: ;
        endcase
      end
      OP_LOAD:  if (f3 == 3'd2) d = ok(CLS_LW);
      OP_STORE: if (f3 == 3'd2) d = ok(CLS_SW);
      OP_JALR:  if (f3 == 3'd0) d = ok(5'd22);
      OP_JAL:   d = ok(5'd23);
      OP_BRANCH: begin
        case (f3)
          3'd0, 3'd1, 3'd4, 3'd5: d = ok(CLS_BR);
          3'd6, 3'd7:             d = ok(CLS_BRU);
          default: ;
        endcase
      end
      OP_LUI:   d = ok(CLS_LUI);
      OP_AUIPC: d = ok(CLS_AUIPC);
      default: ;
    endcase
    return d;
  endfunction

  function automatic stage_e first_after_if(input logic [4:0] c);
    case (c)
      CLS_LUI:   return ST_WB;
      CLS_AUIPC: return ST_EX;
      default:   return ST_ID;
    endcase
  endfunction

  function automatic stage_e final_stage(input logic [4:0] c);
    case (c)
      CLS_LW:          return ST_WB;
      CLS_SW:          return ST_MEM;
      CLS_BR, CLS_BRU: return ST_EX;
      default:         return ST_WB;
    endcase
  endfunction

  // Only consulted for a non-final stage, so the WB and out-of-range cases fall to IF.
  function automatic stage_e after(input logic [4:0] c, input stage_e s);
    case (s)
      ST_ID:   return ST_EX;
      ST_EX:   return (c == CLS_LW || c == CLS_SW) ? ST_MEM : ST_WB;
      ST_MEM:  return ST_WB;
      default: return ST_IF;
    endcase
  endfunction

  stage_e                stage_q, stage_d;
  logic [4:0]            class_q, class_d;
  logic                  halt_q, halt_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  decode_t               dec;
  logic                  is_final;
  logic                  unused_inst_fields;

  assign dec                = decode(imem_inst[6:0], imem_inst[14:12], imem_inst[31:25]);
  assign is_final           = (stage_q == final_stage(class_q));
  assign unused_inst_fields = ^{imem_inst[24:15], imem_inst[11:7]};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    stage_d = stage_q;
    class_d = class_q;
    halt_d  = halt_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    if (!halt_q && !stall) begin
      if (stage_q == ST_IF) begin
        if (dec.legal) begin
          class_d = dec.cls;
          stage_d = first_after_if(dec.cls);
        end else begin
          class_d = HALT_CLASS;
          halt_d  = 1'b1;
        end
      end else if (is_final) begin
        retire  = 1'b1;
        stage_d = ST_IF;
        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end else begin
        stage_d = after(class_q, stage_q);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      stage_q <= ST_IF;
      class_q <= 5'd0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values together.
      stage_q <= stage_d;
      class_q <= class_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign inst_class  = halt_q ? HALT_CLASS : ((stage_q == ST_IF) ? dec.cls : class_q);
  assign stage       = stage_q;
  assign halt        = halt_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: directed multi-cycle sequences, a decode vector table,
// and randomized traffic against a rule-table / stage-list reference model.
module tb_ucode_sequencer;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [31:0] imem_inst = 32'h0;
  logic        stall = 1'b0;

  logic [4:0]  inst_class;
  logic [2:0]  stage;
  logic        halt;
  logic        retire;
  logic [31:0] retired_cnt;

  logic [4:0]  w_class;
  logic [2:0]  w_stage;
  logic        w_halt;
  logic        w_retire;
  logic [1:0]  w_cnt;

  ucode_sequencer dut (
    .CLK(CLK), .RSTn(RSTn), .imem_inst(imem_inst), .stall(stall),
    .inst_class(inst_class), .stage(stage), .halt(halt), .retire(retire),
    .retired_cnt(retired_cnt)
  );

  // Narrow counter instance so wrap-around is reachable.
  ucode_sequencer #(.CNT_WIDTH(2)) dut_w (
    .CLK(CLK), .RSTn(RSTn), .imem_inst(imem_inst), .stall(stall),
    .inst_class(w_class), .stage(w_stage), .halt(w_halt), .retire(w_retire),
    .retired_cnt(w_cnt)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input int cls, input int stg,
                            input bit ret, input bit hlt);
    check({tag, ".class"},  32'(inst_class), cls);
    check({tag, ".stage"},  32'(stage),      stg);
    check({tag, ".retire"}, 32'(retire),     32'(ret));
    check({tag, ".halt"},   32'(halt),       32'(hlt));
  endtask

  // ---------------- reference model ----------------
  typedef struct { int op; int f3; int f7; int cls; } rule_t;
  rule_t rules[$];
  int    seq_tab [32][5];
  int    seq_len [32];

  task automatic add_rule(input int op, input int f3, input int f7, input int cls);
    rule_t r;
    r.op = op; r.f3 = f3; r.f7 = f7; r.cls = cls;
    rules.push_back(r);
  endtask

  function automatic int ref_decode(input logic [31:0] w);
    int op, f3, f7;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    for (int i = 0; i < rules.size(); i++)
      if (rules[i].op == op && (rules[i].f3 < 0 || rules[i].f3 == f3) &&
          (rules[i].f7 < 0 || rules[i].f7 == f7))
        return rules[i].cls;
    return 28;
  endfunction

  task automatic init_model();
    add_rule('h33,0,0,0);  add_rule('h33,0,'h20,1); add_rule('h33,2,0,2); add_rule('h33,3,0,3);
    add_rule('h33,4,0,4);  add_rule('h33,6,0,5);    add_rule('h33,7,0,6); add_rule('h33,1,0,7);
    add_rule('h33,5,0,8);  add_rule('h33,5,'h20,9);
    add_rule('h13,0,-1,10); add_rule('h13,2,-1,12); add_rule('h13,3,-1,13); add_rule('h13,4,-1,14);
    add_rule('h13,6,-1,15); add_rule('h13,7,-1,16); add_rule('h13,1,0,17);  add_rule('h13,5,0,18);
    add_rule('h13,5,'h20,19);
    add_rule('h03,2,-1,20); add_rule('h23,2,-1,21); add_rule('h67,0,-1,22); add_rule('h6F,-1,-1,23);
    add_rule('h63,0,-1,24); add_rule('h63,1,-1,24); add_rule('h63,4,-1,24); add_rule('h63,5,-1,24);
    add_rule('h63,6,-1,25); add_rule('h63,7,-1,25);
    add_rule('h37,-1,-1,26); add_rule('h17,-1,-1,27);
    for (int c = 0; c < 32; c++) begin
      seq_tab[c] = '{0, 1, 2, 4, 0};
      seq_len[c] = 4;
    end
    seq_tab[20] = '{0, 1, 2, 3, 4}; seq_len[20] = 5;
    seq_tab[21] = '{0, 1, 2, 3, 0}; seq_len[21] = 4;
    seq_tab[24] = '{0, 1, 2, 0, 0}; seq_len[24] = 3;
    seq_tab[25] = '{0, 1, 2, 0, 0}; seq_len[25] = 3;
    seq_tab[26] = '{0, 4, 0, 0, 0}; seq_len[26] = 2;
    seq_tab[27] = '{0, 2, 4, 0, 0}; seq_len[27] = 3;
  endtask

  int m_idx, m_cls, m_cnt;
  bit m_halt;

  task automatic model_reset();
    m_idx = 0; m_cls = 0; m_cnt = 0; m_halt = 1'b0;
  endtask

  task automatic model_compare(input string tag);
    int ecls, estg;
    bit eret;
    if (m_halt) begin
      ecls = 28; estg = 0; eret = 1'b0;
    end else if (m_idx == 0) begin
      ecls = ref_decode(imem_inst); estg = 0; eret = 1'b0;
    end else begin
      ecls = m_cls; estg = seq_tab[m_cls][m_idx];
      eret = (m_idx == seq_len[m_cls] - 1) && !stall;
    end
    expect_out(tag, ecls, estg, eret, m_halt);
    check({tag, ".cnt"},   retired_cnt, 32'(m_cnt));
    check({tag, ".wcnt"},  32'(w_cnt),   32'(m_cnt % 4));
    check({tag, ".wstage"}, 32'(w_stage), 32'(estg));
  endtask

  task automatic model_step();
    int d;
    if (m_halt || stall) return;
    if (m_idx == 0) begin
      d = ref_decode(imem_inst);
      if (d == 28) m_halt = 1'b1;
      else begin m_cls = d; m_idx = 1; end
    end else if (m_idx == seq_len[m_cls] - 1) begin
      m_idx = 0;
      m_cnt++;
    end else begin
      m_idx++;
    end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [9];
    logic [31:0] w;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    int          r;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h6F, 7'h63, 7'h37, 7'h17};
    w = $urandom;
    op = (($urandom_range(0, 99) < 98) ? ops[$urandom_range(0, 8)] : w[6:0]);
    f3 = 3'($urandom_range(0, 7));
    if ((op == 7'h03 || op == 7'h23) && $urandom_range(0, 9) < 8) f3 = 3'd2;
    if (op == 7'h67 && $urandom_range(0, 9) < 8) f3 = 3'd0;
    r = $urandom_range(0, 99);
    f7 = (r < 70) ? 7'h00 : (r < 95) ? 7'h20 : w[31:25];
    w[6:0] = op; w[14:12] = f3; w[31:25] = f7;
    return w;
  endfunction

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [6:0] op);
    return {f7, 5'd3, 5'd2, f3, 5'd1, op};
  endfunction

  typedef struct packed { logic [31:0] inst; logic [4:0] cls; } dvec_t;
  dvec_t vecs[$];

  initial begin
    int hold;
    init_model();

    // ---- 1: reset, then addi ----
    imem_inst = 32'h00500093;
    #3;
    expect_out("rst", 10, 0, 0, 0);
    check("rst.cnt", retired_cnt, 0);
    @(negedge CLK); RSTn = 1'b1; #1;
    expect_out("addi.if", 10, 0, 0, 0);
    tick(); expect_out("addi.id", 10, 1, 0, 0);
    tick(); expect_out("addi.ex", 10, 2, 0, 0);
    tick(); expect_out("addi.wb", 10, 4, 1, 0);
    tick(); expect_out("addi.done", 10, 0, 0, 0);
    check("addi.cnt", retired_cnt, 1);

    // ---- 2: lw then sw ----
    imem_inst = 32'h0000A103; #1;
    expect_out("lw.if", 20, 0, 0, 0);
    tick(); expect_out("lw.id", 20, 1, 0, 0);
    tick(); expect_out("lw.ex", 20, 2, 0, 0);
    tick(); expect_out("lw.mem", 20, 3, 0, 0);
    tick(); expect_out("lw.wb", 20, 4, 1, 0);
    tick(); imem_inst = 32'h00112023; #1;
    expect_out("sw.if", 21, 0, 0, 0);
    tick(); expect_out("sw.id", 21, 1, 0, 0);
    tick(); expect_out("sw.ex", 21, 2, 0, 0);
    tick(); expect_out("sw.mem", 21, 3, 1, 0);
    tick(); check("sw.cnt", retired_cnt, 3);
    check("sw.stage", 32'(stage), 0);

    // ---- 3: lui (with stall in WB), auipc ----
    imem_inst = 32'h123450B7; #1;
    expect_out("lui.if", 26, 0, 0, 0);
    tick(); expect_out("lui.wb", 26, 4, 1, 0);
    stall = 1'b1; #1;
    expect_out("lui.wb_stall", 26, 4, 0, 0);
    tick(); expect_out("lui.wb_hold", 26, 4, 0, 0);
    check("lui.cnt_hold", retired_cnt, 3);
    stall = 1'b0; #1;
    check("lui.retire", 32'(retire), 1);
    tick(); imem_inst = 32'h00000097; #1;
    expect_out("auipc.if", 27, 0, 0, 0);
    tick(); expect_out("auipc.ex", 27, 2, 0, 0);
    tick(); expect_out("auipc.wb", 27, 4, 1, 0);
    tick(); check("auipc.cnt", retired_cnt, 5);

    // ---- 4: beq with 3-cycle stall in ID; stall in IF defers the latch ----
    imem_inst = 32'h00000463; #1;
    expect_out("beq.if", 24, 0, 0, 0);
    tick(); expect_out("beq.id", 24, 1, 0, 0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out($sformatf("beq.stall%0d", i), 24, 1, 0, 0);
    end
    stall = 1'b0; #1;
    expect_out("beq.unstall", 24, 1, 0, 0);
    tick(); expect_out("beq.ex", 24, 2, 1, 0);
    tick(); check("beq.cnt", retired_cnt, 6);
    stall = 1'b1; #1;
    tick(); expect_out("ifstall.beq", 24, 0, 0, 0);
    imem_inst = 32'h123450B7; #1;
    expect_out("ifstall.lui", 26, 0, 0, 0);
    stall = 1'b0;
    tick(); expect_out("ifstall.latched", 26, 4, 1, 0);
    tick(); check("ifstall.cnt", retired_cnt, 7);

    // ---- 5: illegal -> sticky halt ----
    imem_inst = 32'hFFFFFFFF; #1;
    expect_out("ill.if", 28, 0, 0, 0);
    tick(); expect_out("ill.halt", 28, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      stall = 1'($urandom_range(0, 1));
      imem_inst = (i % 2 == 0) ? 32'h00500093 : $urandom;
      #1;
      expect_out($sformatf("halt.hold%0d", i), 28, 0, 0, 1);
      check($sformatf("halt.cnt%0d", i), retired_cnt, 7);
      tick();
    end
    stall = 1'b0;
    RSTn = 1'b0; #2; RSTn = 1'b1; #1;
    check("halt.cleared", 32'(halt), 0);
    check("halt.rst_cnt", retired_cnt, 0);

    // ---- 6: async reset mid-EX of sub ----
    imem_inst = 32'h40208033; #1;
    expect_out("sub.if", 1, 0, 0, 0);
    tick(); expect_out("sub.id", 1, 1, 0, 0);
    tick(); expect_out("sub.ex", 1, 2, 0, 0);
    #2; RSTn = 1'b0; #1;
    check("arst.stage", 32'(stage), 0);
    check("arst.halt", 32'(halt), 0);
    check("arst.cnt", retired_cnt, 0);
    @(negedge CLK); RSTn = 1'b1;

    // ---- decode table, applied with stall held in IF ----
    vecs.push_back('{mk(7'h00,3'd0,7'h33), 5'd0});  vecs.push_back('{mk(7'h20,3'd0,7'h33), 5'd1});
    vecs.push_back('{mk(7'h00,3'd2,7'h33), 5'd2});  vecs.push_back('{mk(7'h00,3'd3,7'h33), 5'd3});
    vecs.push_back('{mk(7'h00,3'd4,7'h33), 5'd4});  vecs.push_back('{mk(7'h00,3'd6,7'h33), 5'd5});
    vecs.push_back('{mk(7'h00,3'd7,7'h33), 5'd6});  vecs.push_back('{mk(7'h00,3'd1,7'h33), 5'd7});
    vecs.push_back('{mk(7'h00,3'd5,7'h33), 5'd8});  vecs.push_back('{mk(7'h20,3'd5,7'h33), 5'd9});
    vecs.push_back('{mk(7'h7F,3'd0,7'h13), 5'd10}); vecs.push_back('{mk(7'h00,3'd2,7'h13), 5'd12});
    vecs.push_back('{mk(7'h00,3'd3,7'h13), 5'd13}); vecs.push_back('{mk(7'h00,3'd4,7'h13), 5'd14});
    vecs.push_back('{mk(7'h00,3'd6,7'h13), 5'd15}); vecs.push_back('{mk(7'h00,3'd7,7'h13), 5'd16});
    vecs.push_back('{mk(7'h00,3'd1,7'h13), 5'd17}); vecs.push_back('{mk(7'h00,3'd5,7'h13), 5'd18});
    vecs.push_back('{mk(7'h20,3'd5,7'h13), 5'd19}); vecs.push_back('{mk(7'h00,3'd2,7'h03), 5'd20});
    vecs.push_back('{mk(7'h00,3'd2,7'h23), 5'd21}); vecs.push_back('{mk(7'h00,3'd0,7'h67), 5'd22});
    vecs.push_back('{mk(7'h55,3'd3,7'h6F), 5'd23}); vecs.push_back('{mk(7'h00,3'd0,7'h63), 5'd24});
    vecs.push_back('{mk(7'h00,3'd5,7'h63), 5'd24}); vecs.push_back('{mk(7'h00,3'd6,7'h63), 5'd25});
    vecs.push_back('{mk(7'h00,3'd7,7'h63), 5'd25}); vecs.push_back('{mk(7'h12,3'd5,7'h37), 5'd26});
    vecs.push_back('{mk(7'h00,3'd0,7'h17), 5'd27});
    vecs.push_back('{mk(7'h01,3'd0,7'h33), 5'd28}); vecs.push_back('{mk(7'h20,3'd1,7'h33), 5'd28});
    vecs.push_back('{mk(7'h20,3'd1,7'h13), 5'd28}); vecs.push_back('{mk(7'h10,3'd5,7'h13), 5'd28});
    vecs.push_back('{mk(7'h00,3'd0,7'h03), 5'd28}); vecs.push_back('{mk(7'h00,3'd0,7'h23), 5'd28});
    vecs.push_back('{mk(7'h00,3'd1,7'h67), 5'd28}); vecs.push_back('{mk(7'h00,3'd2,7'h63), 5'd28});
    vecs.push_back('{mk(7'h00,3'd0,7'h7F), 5'd28}); vecs.push_back('{32'h0, 5'd28});
    stall = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      imem_inst = vecs[i].inst; #1;
      check($sformatf("dec[%0d].class", i), 32'(inst_class), 32'(vecs[i].cls));
      check($sformatf("dec[%0d].stage", i), 32'(stage), 0);
    end
    stall = 1'b0;

    // ---- randomized traffic against the reference model ----
    @(posedge CLK); #1;
    RSTn = 1'b0; #1; RSTn = 1'b1; #1;
    model_reset();
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ((m_halt && hold > 3) || $urandom_range(0, 399) == 0) begin
        RSTn = 1'b0; #1; RSTn = 1'b1; #1;
        model_reset();
        hold = 0;
      end
      stall = ($urandom_range(0, 3) == 0);
      imem_inst = rand_inst();
      #1;
      model_compare($sformatf("rnd[%0d]", i));
      model_step();
      if (m_halt) hold++;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
